wb_arbiter: RTL and testbench

//  Writeback-side producer for the 2R/1W write-through register file. Merges

---
 rtl/riscv_pkg.sv | 16 +
 rtl/wb_fifo.sv | 71 +++++++
 rtl/wb_arbiter.sv | 119 +++++++++++
 tb/tb_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared writeback types: register file geometry and the {rd, wd} request record.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    // One writeback request: destination register plus result data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Sync FIFO of writeback requests with per-entry valid/rd export for hazard tracking.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_req_t                       push_dat,
    input  logic                          pop,
    output wb_req_t                       head_dat,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              entry_vld,
    output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign head_dat = mem[rptr];

    // Pointers, occupancy and per-entry valid bits; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (pop) begin
                rptr            <= rptr + 1'b1;
                entry_vld[rptr] <= 1'b0;
            end
            if (push) begin
                wptr            <= wptr + 1'b1;
                entry_vld[wptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; no reset needed because entry_vld qualifies every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_dat;
        end
    end

    // Expose each slot's destination register for the busy mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i] = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU (fixed priority) and queued/bypassed LSU results onto the single RF write port.
// Latency: ALU and LSU bypass 1 cycle to rf_*; queued LSU results 2 or more cycles.
// Backpressure: ALU never stalls; LSU sees lsu_ready = !full from registered occupancy only.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_wd,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_wd,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wd,
    output logic [NREG-1:0]   busy_mask,
    output logic              waw_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t                      alu_req;
    wb_req_t                      lsu_req;
    wb_req_t                      head_req;
    wb_req_t                      sel_req;
    logic                         sel_vld;
    logic                         bypass;
    logic                         fifo_pop;
    logic                         fifo_push;
    logic [CW-1:0]                fifo_count;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [DEPTH-1:0]             entry_vld;
    logic [DEPTH-1:0][REG_AW-1:0] entry_rd;

    assign alu_req   = '{rd: alu_rd, wd: alu_wd};
    assign lsu_req   = '{rd: lsu_rd, wd: lsu_wd};
    assign lsu_ready = !fifo_full;
    // A bypassed result owns the slot directly, so it must not also be queued.
    assign fifo_push = lsu_valid && lsu_ready && !bypass;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_dat  (lsu_req),
        .pop       (fifo_pop),
        .head_dat  (head_req),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .entry_vld (entry_vld),
        .entry_rd  (entry_rd)
    );

    // Slot select: ALU first, then oldest queued LSU result, then same-cycle LSU bypass.
    always_comb begin
        sel_vld  = 1'b0;
        sel_req  = '0;
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        if (alu_valid) begin
            sel_vld = 1'b1;
            sel_req = alu_req;
        end else if (!fifo_empty) begin
            sel_vld  = 1'b1;
            sel_req  = head_req;
            fifo_pop = 1'b1;
        end else if (lsu_valid) begin
            sel_vld = 1'b1;
            sel_req = lsu_req;
            bypass  = 1'b1;
        end
    end

    // Registers with queued writes; x0 is never busy since its writes are dropped.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) begin
                busy_mask[entry_rd[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    // Output register: writes to x0 are suppressed; rd/wd hold when no slot is selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= sel_vld && (sel_req.rd != '0);
            if (sel_vld) begin
                rf_rd <= sel_req.rd;
                rf_wd <= sel_req.wd;
            end
        end
    end

    // Sticky flag: an ALU write landed on a register that an older queued LSU result will clobber.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waw_err <= 1'b0;
        end else if (alu_valid && (alu_rd != '0) && busy_mask[alu_rd]) begin
            waw_err <= 1'b1;
        end
    end

    // Occupancy can never exceed the FIFO size.
    a_count_bound: assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0;
    logic [REG_AW-1:0] alu_rd = '0;
    logic [XLEN-1:0]   alu_wd = '0;
    logic              lsu_valid = 1'b0;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd = '0;
    logic [XLEN-1:0]   lsu_wd = '0;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wd;
    logic [NREG-1:0]   busy_mask;
    logic              waw_err;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_wd    (alu_wd),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_wd    (lsu_wd),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd),
        .busy_mask (busy_mask),
        .waw_err   (waw_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: pending LSU results as a plain queue, plus the expected output port values.
    wb_req_t           mq[$];
    logic              m_we  = 1'b0;
    logic [REG_AW-1:0] m_rd  = '0;
    logic [XLEN-1:0]   m_wd  = '0;
    logic              m_waw = 1'b0;

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] b = '0;
        foreach (mq[i]) begin
            if (mq[i].rd != 0) b = b | (NREG'(1) << mq[i].rd);
        end
        return b;
    endfunction

    // One clock: entered just after a falling edge, returns just after the next falling edge.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                        output logic acc);
        logic            ready;
        logic [NREG-1:0] busy;
        wb_req_t         sel;
        logic            sv;
        logic            byp;
        alu_valid = av; alu_rd = ard; alu_wd = awd;
        lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
        ready = (mq.size() < DEPTH);
        busy  = m_busy();
        #1;
        chk("lsu_ready", lsu_ready, ready);
        chk("busy_mask", busy_mask, busy);
        chk("rf_we", rf_we, m_we);
        chk("rf_rd", rf_rd, m_rd);
        chk("rf_wd", rf_wd, m_wd);
        chk("waw_err", waw_err, m_waw);
        sv = 1'b0; byp = 1'b0; sel = '0;
        if (av) begin
            sv  = 1'b1;
            sel = '{rd: ard, wd: awd};
            if (ard != 0 && busy[ard]) m_waw = 1'b1;
        end else if (mq.size() > 0) begin
            sv  = 1'b1;
            sel = mq.pop_front();
        end else if (lv) begin
            sv  = 1'b1;
            byp = 1'b1;
            sel = '{rd: lrd, wd: lwd};
        end
        acc = lv && ready;
        if (acc && !byp) mq.push_back('{rd: lrd, wd: lwd});
        if (sv) begin
            m_we = (sel.rd != 0);
            m_rd = sel.rd;
            m_wd = sel.wd;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic do_reset();
        alu_valid = 0; lsu_valid = 0;
        rst = 1'b1;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_waw", waw_err, 0);
        mq.delete();
        m_we = 0; m_rd = 0; m_wd = 0; m_waw = 0;
        #1 rst = 1'b0;
        #1 chk("rst_ready", lsu_ready, 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] awd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] ewd;
        logic        erdy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic        acc;
        int          nxt;
        logic [4:0]  seen[$];
        logic        pend;
        logic [4:0]  prd;
        logic [31:0] pwd;

        // Single-cycle vectors from an empty FIFO: expected rf_* after the cycle.
        for (int r = 1; r <= 8; r++)
            tbl.push_back('{1'b1, 5'(r), 32'(r * 'h11), 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 32'(r * 'h11), 1'b1});
        tbl.push_back('{1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1});
        tbl.push_back('{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 1'b1});
        tbl.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1});
        tbl.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 32'h44, 1'b1});

        @(negedge clk);
        do_reset();

        // Table: ALU stream, bypass, hold, queued LSU behind ALU.
        foreach (tbl[i]) begin
            step(tbl[i].av, tbl[i].ard, tbl[i].awd, tbl[i].lv, tbl[i].lrd, tbl[i].lwd, acc);
            chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].ewe);
            chk($sformatf("tbl%0d_rd", i), rf_rd, tbl[i].erd);
            chk($sformatf("tbl%0d_wd", i), rf_wd, tbl[i].ewd);
            chk($sformatf("tbl%0d_ready", i), lsu_ready, tbl[i].erdy);
        end

        // Reset with three entries queued: nothing queued may ever be written.
        for (int c = 0; c < 3; c++) step(1, 1, 32'h1, 1, 5'(20 + c), 32'hA0 + c, acc);
        chk("preq_busy", busy_mask, 32'h0070_0000);
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0, 0, 0, acc);
            chk($sformatf("postrst_we%0d", c), rf_we, 0);
        end

        // Contention: ALU holds the slot while LSU offers 9..14.
        nxt = 9;
        for (int c = 0; c < 6; c++) begin
            step(1, 5'(1 + c), 32'h100 + c, nxt <= 14, 5'(nxt), 32'(nxt * 'h100), acc);
            if (acc) nxt++;
            if (c == 3) begin
                chk("cont_busy", busy_mask, 32'h0000_1E00);
                chk("cont_ready", lsu_ready, 0);
            end
        end
        chk("cont_accepted4", nxt, 13);
        for (int c = 0; c < 20; c++) begin
            step(0, 0, 0, nxt <= 14, 5'(nxt), 32'(nxt * 'h100), acc);
            if (acc) nxt++;
            if (rf_we) seen.push_back(rf_rd);
        end
        chk("cont_accepted_all", nxt, 15);
        chk("cont_drain_cnt", seen.size(), 6);
        for (int k = 0; k < 6 && k < seen.size(); k++)
            chk($sformatf("cont_order%0d", k), seen[k], 9 + k);

        // rd=0: accepted and queued but never written, never busy.
        step(1, 2, 32'h22, 1, 0, 32'hABC, acc);
        chk("rd0_acc", acc, 1);
        chk("rd0_busy", busy_mask, 0);
        step(0, 0, 0, 0, 0, 0, acc);
        chk("rd0_we", rf_we, 0);
        idle(2);

        // WAW: ALU writes r7 while an older r7 result is queued.
        step(1, 3, 32'h33, 1, 7, 32'h7070, acc);
        step(1, 7, 32'h7777, 0, 0, 0, acc);
        chk("waw_set", waw_err, 1);
        chk("waw_alu_we", rf_we, 1);
        chk("waw_alu_wd", rf_wd, 32'h7777);
        idle(4);
        chk("waw_sticky", waw_err, 1);
        do_reset();

        // Random soak against the queue model, LSU holds each offer until accepted.
        pend = 0; prd = 0; pwd = 0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 1) == 1);
                prd  = 5'($urandom_range(0, 31));
                pwd  = $urandom;
            end
            step($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom, pend, prd, pwd, acc);
            if (acc) pend = 0;
        end
        idle(8);
        chk("soak_empty", busy_mask, 0);
        chk("soak_ready", lsu_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
